// File: rtl/cond_unit_if.sv
// Execute-stage bundle between decoder/ALU and the condition unit.
// The slave side is the condition unit; the master side drives instructions and reads results.
interface cond_unit_if;
  logic [3:0] alu_flags;
  logic       instr_valid;
  logic [3:0] cond;
  logic [1:0] flag_w;
  logic       pc_src_in;
  logic       reg_write_in;
  logic       mem_write_in;
  logic       save_flags;
  logic       restore_flags;
  logic [3:0] flags_o;
  logic       cond_ex;
  logic       pc_src;
  logic       reg_write;
  logic       mem_write;
  logic [3:0] shadow_cnt;
  logic       stack_err;

  modport master (
    output alu_flags, instr_valid, cond, flag_w, pc_src_in, reg_write_in, mem_write_in,
           save_flags, restore_flags,
    input  flags_o, cond_ex, pc_src, reg_write, mem_write, shadow_cnt, stack_err
  );

  modport slave (
    input  alu_flags, instr_valid, cond, flag_w, pc_src_in, reg_write_in, mem_write_in,
           save_flags, restore_flags,
    output flags_o, cond_ex, pc_src, reg_write, mem_write, shadow_cnt, stack_err
  );
endinterface

// File: rtl/cond_unit.sv
// NZCV flag register with condition evaluation, strobe gating and a shadow stack
// that preserves flags across nested interrupt entry and return.
module cond_unit #(
  parameter int unsigned SHADOW_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  cond_unit_if.slave  bus
);

  localparam int unsigned FLAG_W = 4;
  localparam int unsigned CNT_W  = 4;

  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [FLAG_W-1:0] shadow_q [SHADOW_DEPTH];
  logic [FLAG_W-1:0] shadow_d [SHADOW_DEPTH];

  logic n_f, z_f, c_f, v_f;
  logic cond_ex_c;
  logic flag_wr;
  logic push, pop;

  assign n_f = flags_q[3];
  assign z_f = flags_q[2];
  assign c_f = flags_q[1];
  assign v_f = flags_q[0];

  // Condition decode against the pre-update flags so the result is available this cycle.
  always_comb begin
    cond_ex_c = 1'b0;
    unique case (bus.cond)
      4'h0: cond_ex_c = z_f;
      4'h1: cond_ex_c = ~z_f;
      4'h2: cond_ex_c = c_f;
      4'h3: cond_ex_c = ~c_f;
      4'h4: cond_ex_c = n_f;
      4'h5: cond_ex_c = ~n_f;
      4'h6: cond_ex_c = v_f;
      4'h7: cond_ex_c = ~v_f;
      4'h8: cond_ex_c = c_f & ~z_f;
      4'h9: cond_ex_c = ~c_f | z_f;
      4'hA: cond_ex_c = (n_f == v_f);
      4'hB: cond_ex_c = (n_f != v_f);
      4'hC: cond_ex_c = ~z_f & (n_f == v_f);
      4'hD: cond_ex_c = z_f | (n_f != v_f);
      4'hE: cond_ex_c = 1'b1;
      default: cond_ex_c = 1'b0;
    endcase
  end

  assign flag_wr = bus.instr_valid & cond_ex_c;
  assign push    = bus.save_flags & ~bus.restore_flags;
  assign pop     = bus.restore_flags & ~bus.save_flags;

  // Next state: flag write first, then a successful pop overrides it.
  always_comb begin
    flags_d  = flags_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    shadow_d = shadow_q;

    if (flag_wr) begin
      if (bus.flag_w[1]) flags_d[3:2] = bus.alu_flags[3:2];
      if (bus.flag_w[0]) flags_d[1:0] = bus.alu_flags[1:0];
    end

    if (bus.save_flags & bus.restore_flags) begin
      err_d = 1'b1;
    end else if (push) begin
      if (cnt_q == CNT_W'(SHADOW_DEPTH)) begin
        err_d = 1'b1;
      end else begin
        for (int unsigned i = 0; i < SHADOW_DEPTH; i++) begin
          if (cnt_q == CNT_W'(i)) shadow_d[i] = flags_q;
        end
        cnt_d = CNT_W'(cnt_q + CNT_W'(1));
      end
    end else if (pop) begin
      if (cnt_q == CNT_W'(0)) begin
        err_d = 1'b1;
      end else begin
        for (int unsigned i = 0; i < SHADOW_DEPTH; i++) begin
          if (cnt_q == CNT_W'(i + 1)) flags_d = shadow_q[i];
        end
        cnt_d = CNT_W'(cnt_q - CNT_W'(1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < SHADOW_DEPTH; i++) shadow_q[i] <= '0;
    end else begin
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      for (int unsigned i = 0; i < SHADOW_DEPTH; i++) shadow_q[i] <= shadow_d[i];
    end
  end

  assign bus.flags_o    = flags_q;
  assign bus.shadow_cnt = cnt_q;
  assign bus.stack_err  = err_q;
  assign bus.cond_ex    = cond_ex_c;
  assign bus.pc_src     = bus.pc_src_in    & cond_ex_c & bus.instr_valid;
  assign bus.reg_write  = bus.reg_write_in & cond_ex_c & bus.instr_valid;
  assign bus.mem_write  = bus.mem_write_in & cond_ex_c & bus.instr_valid;

endmodule
